// File: rtl/iob_bus_arb2_pkg.sv
// -----------------------------------------------------------------------------
// iob_bus_arb2_pkg
// Shared definitions for the two-master IOb bus arbiter:
//   - arb_state_t : FSM state encodings (IDLE / REQ / WAIT_R)
//   - iob_strb_w  : IOb write-strobe width for a given data width
// -----------------------------------------------------------------------------
package iob_bus_arb2_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_REQ    = 2'd1,
    ARB_WAIT_R = 2'd2
  } arb_state_t;

  // One strobe bit per data byte.
  function automatic int iob_strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_bus_arb2_rr.sv
// -----------------------------------------------------------------------------
// iob_rr_arb2
// Combinational 2-way round-robin winner select.
// Ports:
//   i_req[1:0] : request vector (bit n = master n requesting)
//   i_last     : index of the master granted most recently
//   o_grant    : index of the winning master (0 when nobody requests)
// A lone requester always wins; on a tie the master that did not win last
// time is chosen, so a continuous dual request alternates strictly.
// -----------------------------------------------------------------------------
module iob_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant
);

  always_comb begin
    unique case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/iob_bus_arb2.sv
// -----------------------------------------------------------------------------
// iob_bus_arb2
// Two-master to one-slave arbiter for the IOb native bus. Merges the CPU
// instruction bus (master 0) and data bus (master 1) onto one shared slave
// port, one transaction at a time, with round-robin priority. Read data is
// routed only to the master that issued the read.
// Ports:
//   clk_i, cke_i, arst_i         : clock, clock enable (low = hold), async reset
//   m0_* / m1_*                  : IOb master ports (avalid/address/wdata/wstrb
//                                  in; rdata/rvalid/ready out)
//   s_*                          : IOb slave port (avalid/address/wdata/wstrb
//                                  out; rdata/rvalid/ready in)
// -----------------------------------------------------------------------------
module iob_bus_arb2
  import iob_bus_arb2_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,

  input  logic                  m0_avalid_i,
  input  logic [ADDR_W-1:0]     m0_address_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_ready_o,

  input  logic                  m1_avalid_i,
  input  logic [ADDR_W-1:0]     m1_address_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_ready_o,

  output logic                  s_avalid_o,
  output logic [ADDR_W-1:0]     s_address_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_rvalid_i,
  input  logic                  s_ready_i
);

  localparam int STRB_W = iob_strb_w(DATA_W);

  arb_state_t          r_state, w_state_nxt;
  logic                r_sel, w_sel_nxt;
  logic                r_last, w_last_nxt;
  logic                w_winner;
  logic                w_sel_avalid;
  logic [ADDR_W-1:0]   w_sel_address;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_wstrb;

  iob_rr_arb2 u_rr (
    .i_req   ({m1_avalid_i, m0_avalid_i}),
    .i_last  (r_last),
    .o_grant (w_winner)
  );

  // Request of the currently selected master.
  assign w_sel_avalid  = r_sel ? m1_avalid_i  : m0_avalid_i;
  assign w_sel_address = r_sel ? m1_address_i : m0_address_i;
  assign w_sel_wdata   = r_sel ? m1_wdata_i   : m0_wdata_i;
  assign w_sel_wstrb   = r_sel ? m1_wstrb_i   : m0_wstrb_i;

  // last resets to 1 so master 0 wins the first tie.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ARB_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    s_avalid_o  = 1'b0;
    s_address_o = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;

    case (r_state)
      ARB_IDLE: begin
        if (m0_avalid_i || m1_avalid_i) begin
          w_sel_nxt   = w_winner;
          w_state_nxt = ARB_REQ;
        end
      end

      ARB_REQ: begin
        s_avalid_o  = w_sel_avalid;
        s_address_o = w_sel_address;
        s_wdata_o   = w_sel_wdata;
        s_wstrb_o   = w_sel_wstrb;
        if (r_sel) m1_ready_o = s_ready_i;
        else       m0_ready_o = s_ready_i;

        if (w_sel_avalid && s_ready_i) begin
          w_last_nxt  = r_sel;
          // Writes complete on acceptance; reads wait for the response.
          w_state_nxt = (|w_sel_wstrb) ? ARB_IDLE : ARB_WAIT_R;
        end else if (!w_sel_avalid) begin
          // Master withdrew before acceptance: no grant is consumed.
          w_state_nxt = ARB_IDLE;
        end
      end

      ARB_WAIT_R: begin
        // Zero-latency response pass-through to the owner of the read only.
        if (r_sel) begin
          m1_rdata_o  = s_rdata_i;
          m1_rvalid_o = s_rvalid_i;
        end else begin
          m0_rdata_o  = s_rdata_i;
          m0_rvalid_o = s_rvalid_i;
        end
        if (s_rvalid_i) w_state_nxt = ARB_IDLE;
      end

      default: w_state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: doc/iob_bus_arb2.md
Name: iob_bus_arb2

Overview:
- Two-master to one-slave arbiter for the IOb native bus.
- Merges the CPU instruction bus and data bus onto a single shared memory/peripheral port when the system has no split memories.
- Grants one transaction at a time using round-robin priority, and returns read data only to the master that issued the read.
- Placed between the CPU wrapper (ibus/dbus) and the shared memory controller.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk_i  in  1  system clock
- cke_i  in  1  clock enable; when low, all state holds
- arst_i  in  1  reset, asynchronous, active-high
- m0_avalid_i  in  1  master 0 (instruction bus, tie-break winner after reset) request valid
- m0_address_i  in  ADDR_W  master 0 address
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_wstrb_i  in  DATA_W/8  master 0 write strobes; 0 means read
- m0_rdata_o  out  DATA_W  master 0 read data
- m0_rvalid_o  out  1  master 0 read data valid
- m0_ready_o  out  1  master 0 request accepted
- m1_* (avalid_i, address_i, wdata_i, wstrb_i, rdata_o, rvalid_o, ready_o): same set as m0, for master 1 (data bus)
- s_avalid_o  out  1  slave request valid
- s_address_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_wstrb_o  out  DATA_W/8  slave write strobes
- s_rdata_i  in  DATA_W  slave read data
- s_rvalid_i  in  1  slave read data valid
- s_ready_i  in  1  slave accepts request

Behaviour:
- Clock: single clock clk_i.
- Reset: arst_i asynchronous active-high. Reset puts the FSM in IDLE with sel=0 and last=1, so master 0 wins the first tie.
- Reset values: all outputs 0 (s_avalid_o, s_address_o, s_wdata_o, s_wstrb_o, m*_ready_o, m*_rvalid_o, m*_rdata_o).
- FSM states: IDLE, REQ, WAIT_R. All registers update only when cke_i=1.
- IDLE:
  - No master sees ready; s_avalid_o=0.
  - If any m*_avalid_i: sel <= winner, go to REQ.
  - Winner: if only one requests, that one. If both request, the master not equal to last.
- REQ:
  - s_* driven from master sel (address, wdata, wstrb).
  - s_avalid_o = m[sel]_avalid_i.
  - m[sel]_ready_o = s_ready_i; the other master's ready_o=0.
  - On s_avalid_o & s_ready_i:
    - last <= sel.
    - If wstrb≠0 (write): go to IDLE.
    - Else (read): go to WAIT_R.
  - If m[sel]_avalid_i drops before acceptance: go to IDLE, last unchanged.
- WAIT_R:
  - s_avalid_o=0.
  - m[sel]_rdata_o = s_rdata_i and m[sel]_rvalid_o = s_rvalid_i, combinational pass-through.
  - On s_rvalid_i: go to IDLE.
- Outside WAIT_R, all m*_rvalid_o=0 and m*_rdata_o=0. The non-selected master never sees rvalid.
- Latency: 1 cycle of arbitration (IDLE→REQ) plus the slave's accept latency. Read data arrives with zero added latency.
- Throughput: at most one transaction per 2 cycles (writes) or per 2+read-latency cycles (reads).
- Only one outstanding transaction. A slave rvalid outside WAIT_R is ignored.
- s_rvalid_i in the same cycle as acceptance is not legal for the IOb slave; the arbiter ignores it.
- A new request arriving while another is in flight waits. There is no pre-emption.
- Under a continuous dual request, grants strictly alternate 0,1,0,1…
- A reset mid-transaction returns to IDLE immediately. Any in-flight slave response is dropped.

Decomposition:
- Shared package constants: FSM state encodings (ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT_R=2'd2) and the IOb strobe width expression.
- State and sel/last registers use the existing iob_reg_r-style register with arst_i/cke_i.
- Natural sub-module: iob_rr_arb2. This is a combinational 2-way round-robin winner select from (req[1:0], last), reusable for N=2 priority elsewhere.

Test Plan:
- Single read, m0 @0x1000_0000:
  - Slave ready 1 cycle after avalid; rdata 0xDEADBEEF 2 cycles later.
  - Expect m0_rvalid_o=1 with 0xDEADBEEF; m1_rvalid_o stays 0.
- Simultaneous requests after reset:
  - m0 read @0x10, m1 write @0x20 (wdata 0x55, wstrb 0xF).
  - Expect m0 granted first; then m1 write appears on s_* with wstrb 0xF; m0 never sees ready for the m1 cycle.
- Continuous contention, 6 requests each, slave always ready:
  - Expect s_address_o grant order m0,m1,m0,m1,m0,m1…; each master gets exactly 6 ready pulses.
- Write then read, same master m1:
  - Write 0xA5A5A5A5 @0x40, then read @0x40 with slave read latency 3.
  - Expect the write back to IDLE one cycle after acceptance; the read returns on m1 only.
- cke_i low for 4 cycles while in WAIT_R:
  - State holds; rvalid still passes through when cke_i returns.
  - FSM reaches IDLE on the first enabled cycle with s_rvalid_i.
- arst_i pulse while in WAIT_R:
  - All outputs go to 0 asynchronously; a late s_rvalid_i is ignored.
  - The next m0/m1 tie is granted to m0.
